branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Receiving end of the execute stage's branch-resolution outputs.
- Consumes the resolved branch information: pc, isBranch, isBranchTaken and irregPc.
- Maintains a direct-mapped branch target buffer with a 2-bit saturating counter per entry.
- Gives the fetch stage a same-cycle taken/target prediction for the current fetch PC; this prediction is what later travels down the pipe as branchPredict.

Parameters:
- PC_WIDTH, 32, width of all PC values
- ENTRY_NUM, 64, number of BTB entries; power of two, at least 2
- INDEX_WIDTH, $clog2(ENTRY_NUM), index bits; derived, not overridden
- TAG_WIDTH, PC_WIDTH-INDEX_WIDTH-2, tag bits; derived

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- fetchPc  input  PC_WIDTH  PC being fetched this cycle
- predictTaken  output  1  fetchPc predicted taken
- predictTarget  output  PC_WIDTH  predicted target; valid only when predictTaken=1
- exPc  input  PC_WIDTH  PC of the instruction in execute
- exIsBranch  input  1  instruction in execute is a conditional branch/jump; update strobe
- exIsBranchTaken  input  1  resolved direction
- exIrregPc  input  PC_WIDTH  resolved target; meaningful when exIsBranchTaken=1

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous and active-high.
- Address split:
  - index = pc[INDEX_WIDTH+1:2]
  - tag = pc[PC_WIDTH-1:INDEX_WIDTH+2]
  - pc[1:0] ignored
- Entry contents: valid (1), tag (TAG_WIDTH), target (PC_WIDTH), ctr (2).
- Reset:
  - In the cycle rst=1 is sampled, every valid bit clears to 0 and every ctr clears to 2'b01 (weakly not-taken).
  - tag and target are not reset.
  - Updates are ignored while rst=1.
  - Reset mid-operation discards all learned state.
- Lookup (combinational, 0-cycle latency):
  - hit = valid[idx] && tag[idx]==fetchTag.
  - predictTaken = hit && ctr[idx][1].
  - predictTarget = target[idx] when predictTaken, else 0.
  - During and immediately after reset: predictTaken=0, predictTarget=0.
- Update (registered; visible to lookup the following cycle), only when exIsBranch=1 and rst=0:
  - Hit, taken: ctr saturating increment (3 stays 3); target <= exIrregPc.
  - Hit, not taken: ctr saturating decrement (0 stays 0); target unchanged.
  - Miss, taken: allocate. valid<=1, tag<=exTag, target<=exIrregPc, ctr<=2'b10. Unconditionally replaces the existing occupant (aliasing eviction).
  - Miss, not taken: no change; no allocation.
  - exIsBranch=0: no change, regardless of the other ex* inputs.
- Simultaneous lookup and update to the same index in the same cycle: lookup returns pre-update contents (read-before-write); the new contents appear next cycle.
- Index wrap: PCs differing only above bit INDEX_WIDTH+1 share an entry and are distinguished only by tag.
- Arithmetic:
  - Counters are 2-bit unsigned with saturation, never wrapping.
  - No arithmetic on PCs; the target is stored verbatim.
- No stalls or handshakes: one update per cycle, accepted unconditionally.

Test Plan:
1. Reset, then fetchPc=0x0000_0100 -> predictTaken=0, predictTarget=0.
2. Allocation and strengthening:
   - Stimulus: exPc=0x100, exIsBranch=1, exIsBranchTaken=1, exIrregPc=0x200, one cycle.
   - Next cycle, fetchPc=0x100 -> predictTaken=1, predictTarget=0x200 (ctr=2).
   - A second taken update -> ctr=3.
3. Hysteresis and saturation, starting from ctr=3 at 0x100:
   - One not-taken update -> still predictTaken=1 (ctr=2).
   - Second not-taken update -> predictTaken=0 (ctr=1).
   - Two further not-taken updates -> ctr saturates at 0.
   - Next taken update -> ctr=1, predictTaken=0.
4. Aliasing:
   - With 0x100 allocated to 0x200, send a taken update for exPc=0x200 (same index with ENTRY_NUM=64; differs in tag) to 0x400.
   - Then fetchPc=0x100 -> predictTaken=0; fetchPc=0x200 -> predictTaken=1, target 0x400.
   - A not-taken miss for exPc=0x300 leaves the table unchanged.
5. Same-cycle conflict, empty table:
   - fetchPc=0x100 and a taken update for exPc=0x100 in the same cycle -> predictTaken=0 that cycle.
   - Next cycle -> predictTaken=1, predictTarget=update target.
6. Reset mid-operation:
   - Populate 0x100, 0x104 and 0x108.
   - Assert rst for one cycle while exIsBranch=1, exIsBranchTaken=1, exPc=0x10C.
   - Afterwards, fetchPc=0x100, 0x104, 0x108 and 0x10C -> predictTaken=0 for all.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; same-cycle lookup for fetch, registered update from execute.
// Lookup is combinational (read-before-write); one update per cycle, always accepted, no backpressure.
module branch_target_predictor #(
  parameter int PC_WIDTH  = 32,
  parameter int ENTRY_NUM = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] fetchPc,
  output logic                predictTaken,
  output logic [PC_WIDTH-1:0] predictTarget,
  input  logic [PC_WIDTH-1:0] exPc,
  input  logic                exIsBranch,
  input  logic                exIsBranchTaken,
  input  logic [PC_WIDTH-1:0] exIrregPc
);

  localparam int INDEX_WIDTH = $clog2(ENTRY_NUM);
  localparam int TAG_WIDTH   = PC_WIDTH - INDEX_WIDTH - 2;

  logic                valid_q  [ENTRY_NUM];
  logic                valid_d  [ENTRY_NUM];
  logic [TAG_WIDTH-1:0] tag_q   [ENTRY_NUM];
  logic [TAG_WIDTH-1:0] tag_d   [ENTRY_NUM];
  logic [PC_WIDTH-1:0] target_q [ENTRY_NUM];
  logic [PC_WIDTH-1:0] target_d [ENTRY_NUM];
  logic [1:0]          ctr_q    [ENTRY_NUM];
  logic [1:0]          ctr_d    [ENTRY_NUM];

  logic [INDEX_WIDTH-1:0] fetch_idx;
  logic [TAG_WIDTH-1:0]   fetch_tag;
  logic [INDEX_WIDTH-1:0] ex_idx;
  logic [TAG_WIDTH-1:0]   ex_tag;
  logic                   fetch_hit;
  logic                   ex_hit;
  logic                   upd_en;
  logic                   unused_pc_lsbs;

  assign fetch_idx      = fetchPc[INDEX_WIDTH+1:2];
  assign fetch_tag      = fetchPc[PC_WIDTH-1:INDEX_WIDTH+2];
  assign ex_idx         = exPc[INDEX_WIDTH+1:2];
  assign ex_tag         = exPc[PC_WIDTH-1:INDEX_WIDTH+2];
  assign unused_pc_lsbs = ^{fetchPc[1:0], exPc[1:0]};

  // Lookup reads the registered table, so a same-cycle update is not visible until next cycle.
  always_comb begin
    fetch_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    predictTaken  = !rst && fetch_hit && ctr_q[fetch_idx][1];
    predictTarget = predictTaken ? target_q[fetch_idx] : '0;
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    upd_en   = exIsBranch && !rst;
    ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    if (upd_en) begin
      if (ex_hit) begin
        if (exIsBranchTaken) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
          target_d[ex_idx] = exIrregPc;
        end else if (ctr_q[ex_idx] != 2'b00) begin
          ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
        end
      end else if (exIsBranchTaken) begin
        // Taken miss evicts whatever aliases into this slot.
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = exIrregPc;
        ctr_d[ex_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (rst) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end else begin
        valid_q[i] <= valid_d[i];
        ctr_q[i]   <= ctr_d[i];
      end
    end
  end

  // Tag and target carry no reset; a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      tag_q[i]    <= tag_d[i];
      target_q[i] <= target_d[i];
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: vector table plus hand-written reset/conflict sequences.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetchPc;
  logic        predictTaken;
  logic [31:0] predictTarget;
  logic [31:0] exPc;
  logic        exIsBranch;
  logic        exIsBranchTaken;
  logic [31:0] exIrregPc;

  int passed = 0;
  int total  = 0;

  branch_target_predictor #(.PC_WIDTH(32), .ENTRY_NUM(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .fetchPc         (fetchPc),
    .predictTaken    (predictTaken),
    .predictTarget   (predictTarget),
    .exPc            (exPc),
    .exIsBranch      (exIsBranch),
    .exIsBranchTaken (exIsBranchTaken),
    .exIrregPc       (exIrregPc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [31:0] fetch;
    logic [31:0] ex_pc;
    logic        br;
    logic        tk;
    logic [31:0] irreg;
    logic        exp_tk;
    logic [31:0] exp_tgt;
  } vec_t;

  typedef struct {
    string       name;
    logic        tk;
    logic [31:0] tgt;
  } exp_t;

  exp_t  sb[$];
  vec_t  vecs[20];

  // Drive one cycle of inputs just after the edge, check the combinational prediction mid-cycle.
  task automatic apply(input string name, input logic r, input logic [31:0] f,
                       input logic [31:0] ep, input logic b, input logic t,
                       input logic [31:0] ir, input logic etk, input logic [31:0] etg);
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    rst             = r;
    fetchPc         = f;
    exPc            = ep;
    exIsBranch      = b;
    exIsBranchTaken = t;
    exIrregPc       = ir;
    e.name = name;
    e.tk   = etk;
    e.tgt  = etg;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    total++;
    if (predictTaken === got.tk && predictTarget === got.tgt) begin
      passed++;
    end else begin
      $display("FAIL %s: predictTaken=%0b predictTarget=%h, expected %0b/%h",
               got.name, predictTaken, predictTarget, got.tk, got.tgt);
    end
  endtask

  initial begin
    rst             = 1'b1;
    fetchPc         = '0;
    exPc            = '0;
    exIsBranch      = 1'b0;
    exIsBranchTaken = 1'b0;
    exIrregPc       = '0;

    //          rst   fetch         exPc          br    tk    irreg         exp_tk exp_tgt
    vecs[0]  = '{1'b1, 32'h100, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000};
    vecs[1]  = '{1'b0, 32'h100, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000};
    vecs[2]  = '{1'b0, 32'h100, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h000};
    vecs[3]  = '{1'b0, 32'h100, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200};
    vecs[4]  = '{1'b0, 32'h100, 32'h100, 1'b1, 1'b0, 32'h000, 1'b1, 32'h200};
    vecs[5]  = '{1'b0, 32'h100, 32'h100, 1'b1, 1'b0, 32'h000, 1'b1, 32'h200};
    vecs[6]  = '{1'b0, 32'h100, 32'h100, 1'b1, 1'b0, 32'h000, 1'b0, 32'h000};
    vecs[7]  = '{1'b0, 32'h100, 32'h100, 1'b1, 1'b0, 32'h000, 1'b0, 32'h000};
    vecs[8]  = '{1'b0, 32'h100, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h000};
    vecs[9]  = '{1'b0, 32'h100, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h000};
    vecs[10] = '{1'b0, 32'h100, 32'h000, 1'b0, 1'b0, 32'h000, 1'b1, 32'h200};
    vecs[11] = '{1'b0, 32'h200, 32'h200, 1'b1, 1'b1, 32'h400, 1'b0, 32'h000};
    vecs[12] = '{1'b0, 32'h100, 32'h300, 1'b1, 1'b0, 32'h000, 1'b0, 32'h000};
    vecs[13] = '{1'b0, 32'h200, 32'h000, 1'b0, 1'b0, 32'h000, 1'b1, 32'h400};
    vecs[14] = '{1'b0, 32'h300, 32'h200, 1'b0, 1'b1, 32'h999, 1'b0, 32'h000};
    vecs[15] = '{1'b0, 32'h200, 32'h000, 1'b0, 1'b0, 32'h000, 1'b1, 32'h400};
    vecs[16] = '{1'b0, 32'h200, 32'h200, 1'b1, 1'b1, 32'h480, 1'b1, 32'h400};
    vecs[17] = '{1'b0, 32'h200, 32'h000, 1'b0, 1'b0, 32'h000, 1'b1, 32'h480};
    vecs[18] = '{1'b0, 32'h202, 32'h1FC, 1'b1, 1'b1, 32'h010, 1'b1, 32'h480};
    vecs[19] = '{1'b0, 32'h1FC, 32'h000, 1'b0, 1'b0, 32'h000, 1'b1, 32'h010};

    for (int i = 0; i < 20; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].r, vecs[i].fetch, vecs[i].ex_pc, vecs[i].br,
            vecs[i].tk, vecs[i].irreg, vecs[i].exp_tk, vecs[i].exp_tgt);
    end

    // Same-cycle lookup and allocation on an empty table.
    apply("conflict_rst",  1'b1, 32'h100, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000);
    apply("conflict_same", 1'b0, 32'h100, 32'h100, 1'b1, 1'b1, 32'h240, 1'b0, 32'h000);
    apply("conflict_next", 1'b0, 32'h100, 32'h000, 1'b0, 1'b0, 32'h000, 1'b1, 32'h240);

    // Populate neighbours, then reset with an update pending.
    apply("pop_104",       1'b0, 32'h100, 32'h104, 1'b1, 1'b1, 32'h300, 1'b1, 32'h240);
    apply("pop_108",       1'b0, 32'h104, 32'h108, 1'b1, 1'b1, 32'h340, 1'b1, 32'h300);
    apply("pop_chk_108",   1'b0, 32'h108, 32'h000, 1'b0, 1'b0, 32'h000, 1'b1, 32'h340);
    apply("mid_rst",       1'b1, 32'h100, 32'h10C, 1'b1, 1'b1, 32'h500, 1'b0, 32'h000);
    apply("post_rst_100",  1'b0, 32'h100, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000);
    apply("post_rst_104",  1'b0, 32'h104, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000);
    apply("post_rst_108",  1'b0, 32'h108, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000);
    apply("post_rst_10c",  1'b0, 32'h10C, 32'h000, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
